calc2_top: RTL and testbench

CALC2_TOP -- requirements
Module: calc2_top

---
 rtl/calc2_top.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_calc2_top.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc2_top.sv
// calc2_top: four-port request front end feeding two shared execution units.
// Each port captures a two-cycle request (command + op1, then op2), queues it
// in a small in-order FIFO, and competes for ALU-A (add/sub/invalid) or
// ALU-S (shifts) with fixed lowest-port-first priority. Results come back on
// the originating port one cycle after the unit registers the request.
module calc2_top (
  input  logic        c_clk,
  input  logic        reset,

  input  logic [3:0]  req1_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [1:0]  req1_tag_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [31:0] req2_data_in,
  input  logic [1:0]  req2_tag_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [31:0] req3_data_in,
  input  logic [1:0]  req3_tag_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req4_data_in,
  input  logic [1:0]  req4_tag_in,

  output logic [1:0]  out_resp1,
  output logic [31:0] out_data1,
  output logic [1:0]  out_tag1,
  output logic [1:0]  out_resp2,
  output logic [31:0] out_data2,
  output logic [1:0]  out_tag2,
  output logic [1:0]  out_resp3,
  output logic [31:0] out_data3,
  output logic [1:0]  out_tag3,
  output logic [1:0]  out_resp4,
  output logic [31:0] out_data4,
  output logic [1:0]  out_tag4
);

  localparam int NP    = 4;
  localparam int DEPTH = 4;

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  // A complete queued request.
  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  tag;
  } req_t;

  // Per-port capture phase: waiting for a command, or waiting for op2.
  typedef enum logic {
    PORT_IDLE,
    PORT_OP2
  } port_state_t;

  // Flat ports gathered into arrays so per-port logic can be generated.
  logic [3:0]  cmd_in  [NP];
  logic [31:0] data_in [NP];
  logic [1:0]  tag_in  [NP];

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;
  assign tag_in[0]  = req1_tag_in;
  assign tag_in[1]  = req2_tag_in;
  assign tag_in[2]  = req3_tag_in;
  assign tag_in[3]  = req4_tag_in;

  // FIFO heads and their routing requests toward the two units.
  req_t          head   [NP];
  logic [NP-1:0] want_a;
  logic [NP-1:0] want_s;
  logic [NP-1:0] pop;

  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_port
      port_state_t state_q;
      logic [3:0]  cap_cmd_q;
      logic [31:0] cap_op1_q;
      logic [1:0]  cap_tag_q;

      req_t        mem_q [DEPTH];
      logic [1:0]  wr_ptr_q;
      logic [1:0]  rd_ptr_q;
      logic [2:0]  count_q;

      logic        push;
      logic        head_vld;
      logic        head_shift;

      // A full FIFO (judged before this edge's pop) drops the new request.
      assign push       = (state_q == PORT_OP2) && (count_q != 3'(DEPTH));
      assign head_vld   = (count_q != 3'd0);
      assign head[gi]   = mem_q[rd_ptr_q];
      assign head_shift = (mem_q[rd_ptr_q].cmd == CMD_SHL) ||
                          (mem_q[rd_ptr_q].cmd == CMD_SHR);
      assign want_a[gi] = head_vld && !head_shift;
      assign want_s[gi] = head_vld && head_shift;

      // Capture FSM: command/op1/tag in the first cycle, op2 in the second;
      // the command in the op2 cycle is ignored.
      always_ff @(posedge c_clk) begin
        if (reset) begin
          state_q   <= PORT_IDLE;
          cap_cmd_q <= CMD_NONE;
          cap_op1_q <= '0;
          cap_tag_q <= '0;
        end else begin
          case (state_q)
            PORT_IDLE: begin
              if (cmd_in[gi] != CMD_NONE) begin
                cap_cmd_q <= cmd_in[gi];
                cap_op1_q <= data_in[gi];
                cap_tag_q <= tag_in[gi];
                state_q   <= PORT_OP2;
              end
            end
            PORT_OP2: state_q <= PORT_IDLE;
            default:  state_q <= PORT_IDLE;
          endcase
        end
      end

      // FIFO storage; emptiness is governed by the count, so no reset here.
      always_ff @(posedge c_clk) begin
        if (push) begin
          mem_q[wr_ptr_q] <= {cap_cmd_q, cap_op1_q, data_in[gi], cap_tag_q};
        end
      end

      // FIFO pointers and occupancy.
      always_ff @(posedge c_clk) begin
        if (reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          if (push) begin
            wr_ptr_q <= wr_ptr_q + 2'd1;
          end
          if (pop[gi]) begin
            rd_ptr_q <= rd_ptr_q + 2'd1;
          end
          count_q <= count_q + {2'b00, push} - {2'b00, pop[gi]};
        end
      end
    end
  endgenerate

  // Fixed priority per unit: the lowest-numbered port with a matching head.
  logic       gnt_a_vld;
  logic [1:0] gnt_a_idx;
  logic       gnt_s_vld;
  logic [1:0] gnt_s_idx;

  // Scan from the top so the lowest matching port is the last one written.
  always_comb begin
    gnt_a_vld = 1'b0;
    gnt_a_idx = '0;
    gnt_s_vld = 1'b0;
    gnt_s_idx = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (want_a[i]) begin
        gnt_a_vld = 1'b1;
        gnt_a_idx = 2'(i);
      end
      if (want_s[i]) begin
        gnt_s_vld = 1'b1;
        gnt_s_idx = 2'(i);
      end
    end
  end

  // A head targets exactly one unit, so at most one pop per port per cycle.
  always_comb begin
    pop = '0;
    if (gnt_a_vld) begin
      pop[gnt_a_idx] = 1'b1;
    end
    if (gnt_s_vld) begin
      pop[gnt_s_idx] = 1'b1;
    end
  end

  // Unit input registers.
  logic        a_vld_q;
  logic [1:0]  a_port_q;
  req_t        a_req_q;

  logic        s_vld_q;
  logic [1:0]  s_port_q;
  logic        s_right_q;
  logic [31:0] s_op1_q;
  logic [4:0]  s_amt_q;
  logic [1:0]  s_tag_q;

  // Register the granted heads into the units; only op2[4:0] matters for shifts.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      a_vld_q   <= 1'b0;
      a_port_q  <= '0;
      a_req_q   <= '0;
      s_vld_q   <= 1'b0;
      s_port_q  <= '0;
      s_right_q <= 1'b0;
      s_op1_q   <= '0;
      s_amt_q   <= '0;
      s_tag_q   <= '0;
    end else begin
      a_vld_q   <= gnt_a_vld;
      a_port_q  <= gnt_a_idx;
      a_req_q   <= head[gnt_a_idx];
      s_vld_q   <= gnt_s_vld;
      s_port_q  <= gnt_s_idx;
      s_right_q <= (head[gnt_s_idx].cmd == CMD_SHR);
      s_op1_q   <= head[gnt_s_idx].op1;
      s_amt_q   <= head[gnt_s_idx].op2[4:0];
      s_tag_q   <= head[gnt_s_idx].tag;
    end
  end

  // ALU-A: add with carry-out as error, unsigned sub with borrow as error,
  // anything else routed here is an invalid command.
  logic [32:0] a_sum;
  logic [1:0]  a_resp;
  logic [31:0] a_data;

  always_comb begin
    a_sum  = {1'b0, a_req_q.op1} + {1'b0, a_req_q.op2};
    a_resp = RESP_ERR;
    a_data = '0;
    case (a_req_q.cmd)
      CMD_ADD: begin
        if (!a_sum[32]) begin
          a_resp = RESP_OK;
          a_data = a_sum[31:0];
        end
      end
      CMD_SUB: begin
        if (a_req_q.op2 <= a_req_q.op1) begin
          a_resp = RESP_OK;
          a_data = a_req_q.op1 - a_req_q.op2;
        end
      end
      default: begin
        a_resp = RESP_ERR;
        a_data = '0;
      end
    endcase
  end

  // ALU-S: logical shifts always succeed.
  logic [31:0] s_data;

  always_comb begin
    s_data = s_right_q ? (s_op1_q >> s_amt_q) : (s_op1_q << s_amt_q);
  end

  // Per-port output registers.
  logic [1:0]  resp_q  [NP];
  logic [31:0] rdata_q [NP];
  logic [1:0]  rtag_q  [NP];

  // Steer each unit's result to its port for one cycle; idle ports read zero.
  always_ff @(posedge c_clk) begin
    for (int i = 0; i < NP; i++) begin
      if (reset) begin
        resp_q[i]  <= '0;
        rdata_q[i] <= '0;
        rtag_q[i]  <= '0;
      end else if (a_vld_q && (a_port_q == 2'(i))) begin
        resp_q[i]  <= a_resp;
        rdata_q[i] <= a_data;
        rtag_q[i]  <= a_req_q.tag;
      end else if (s_vld_q && (s_port_q == 2'(i))) begin
        resp_q[i]  <= RESP_OK;
        rdata_q[i] <= s_data;
        rtag_q[i]  <= s_tag_q;
      end else begin
        resp_q[i]  <= '0;
        rdata_q[i] <= '0;
        rtag_q[i]  <= '0;
      end
    end
  end

  assign out_resp1 = resp_q[0];
  assign out_data1 = rdata_q[0];
  assign out_tag1  = rtag_q[0];
  assign out_resp2 = resp_q[1];
  assign out_data2 = rdata_q[1];
  assign out_tag2  = rtag_q[1];
  assign out_resp3 = resp_q[2];
  assign out_data3 = rdata_q[2];
  assign out_tag3  = rtag_q[2];
  assign out_resp4 = resp_q[3];
  assign out_data4 = rdata_q[3];
  assign out_tag4  = rtag_q[3];

endmodule

// File: tb/tb_calc2_top.sv
// tb_calc2_top: directed and randomized stimulus for calc2_top, checked every
// cycle against a queue-based behavioural model of the four ports.
module tb_calc2_top;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [3:0]  cmd_v  [4];
  logic [31:0] data_v [4];
  logic [1:0]  tag_v  [4];
  logic [1:0]  resp_w  [4];
  logic [31:0] rdata_w [4];
  logic [1:0]  rtag_w  [4];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_drop = 0;
  int n_resp = 0;
  bit chk_en = 1'b0;

  calc2_top dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req1_cmd_in (cmd_v[0]), .req1_data_in (data_v[0]), .req1_tag_in (tag_v[0]),
    .req2_cmd_in (cmd_v[1]), .req2_data_in (data_v[1]), .req2_tag_in (tag_v[1]),
    .req3_cmd_in (cmd_v[2]), .req3_data_in (data_v[2]), .req3_tag_in (tag_v[2]),
    .req4_cmd_in (cmd_v[3]), .req4_data_in (data_v[3]), .req4_tag_in (tag_v[3]),
    .out_resp1 (resp_w[0]), .out_data1 (rdata_w[0]), .out_tag1 (rtag_w[0]),
    .out_resp2 (resp_w[1]), .out_data2 (rdata_w[1]), .out_tag2 (rtag_w[1]),
    .out_resp3 (resp_w[2]), .out_data3 (rdata_w[2]), .out_tag3 (rtag_w[2]),
    .out_resp4 (resp_w[3]), .out_data4 (rdata_w[3]), .out_tag4 (rtag_w[3])
  );

  initial forever #5 c_clk = ~c_clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  tag;
  } mreq_t;

  mreq_t       mq [4][$];
  int          phase [4];
  mreq_t       cap [4];
  bit          pend_v [4];
  logic [1:0]  pend_resp [4];
  logic [31:0] pend_data [4];
  logic [1:0]  pend_tag [4];
  logic [1:0]  exp_resp [4];
  logic [31:0] exp_data [4];
  logic [1:0]  exp_tag [4];

  function automatic bit is_shift(input logic [3:0] c);
    return (c == 4'd5) || (c == 4'd6);
  endfunction

  task automatic calc(input mreq_t r, output logic [1:0] resp, output logic [31:0] d);
    longint unsigned s;
    resp = 2'd2;
    d    = 32'd0;
    case (r.cmd)
      4'd1: begin
        s = longint'(r.op1) + longint'(r.op2);
        if (s <= 64'hFFFF_FFFF) begin resp = 2'd1; d = r.op1 + r.op2; end
      end
      4'd2: if (r.op2 <= r.op1) begin resp = 2'd1; d = r.op1 - r.op2; end
      4'd5: begin resp = 2'd1; d = r.op1 << (r.op2 % 32); end
      4'd6: begin resp = 2'd1; d = r.op1 >> (r.op2 % 32); end
      default: begin resp = 2'd2; d = 32'd0; end
    endcase
  endtask

  // One clock edge of the model, using the inputs sampled at that edge.
  task automatic model_step();
    int    pre [4];
    bit    took [4];
    mreq_t r;
    if (reset) begin
      for (int p = 0; p < 4; p++) begin
        mq[p].delete();
        phase[p] = 0;
        pend_v[p] = 1'b0;
        exp_resp[p] = 2'd0; exp_data[p] = 32'd0; exp_tag[p] = 2'd0;
      end
      return;
    end
    for (int p = 0; p < 4; p++) begin
      exp_resp[p] = pend_v[p] ? pend_resp[p] : 2'd0;
      exp_data[p] = pend_v[p] ? pend_data[p] : 32'd0;
      exp_tag[p]  = pend_v[p] ? pend_tag[p]  : 2'd0;
      if (pend_v[p]) n_resp++;
      pend_v[p] = 1'b0;
      pre[p]  = mq[p].size();
      took[p] = 1'b0;
    end
    for (int u = 0; u < 2; u++) begin
      for (int p = 0; p < 4; p++) begin
        if (!took[p] && mq[p].size() > 0 && (is_shift(mq[p][0].cmd) == (u == 1))) begin
          r = mq[p].pop_front();
          calc(r, pend_resp[p], pend_data[p]);
          pend_tag[p] = r.tag;
          pend_v[p]   = 1'b1;
          took[p]     = 1'b1;
          break;
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (phase[p] == 0) begin
        if (cmd_v[p] != 4'd0) begin
          cap[p].cmd = cmd_v[p];
          cap[p].op1 = data_v[p];
          cap[p].tag = tag_v[p];
          phase[p] = 1;
        end
      end else begin
        cap[p].op2 = data_v[p];
        if (pre[p] < 4) mq[p].push_back(cap[p]);
        else n_drop++;
        phase[p] = 0;
      end
    end
  endtask

  // ---------------- every-cycle compare ----------------
  always @(negedge c_clk) begin
    if (chk_en) begin
      for (int p = 0; p < 4; p++) begin
        n_cmp++;
        if (resp_w[p] !== exp_resp[p] || rdata_w[p] !== exp_data[p] || rtag_w[p] !== exp_tag[p]) begin
          n_fail++;
          $display("FAIL cycle_port%0d t=%0t: got resp=%0d data=%h tag=%0d, want resp=%0d data=%h tag=%0d",
                   p + 1, $time, resp_w[p], rdata_w[p], rtag_w[p], exp_resp[p], exp_data[p], exp_tag[p]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge c_clk);
    model_step();
    @(negedge c_clk);
  endtask

  task automatic put(input int p, input logic [3:0] c, input logic [31:0] d, input logic [1:0] t);
    cmd_v[p] = c; data_v[p] = d; tag_v[p] = t;
  endtask

  task automatic idle_all();
    for (int p = 0; p < 4; p++) put(p, 4'd0, 32'd0, 2'd0);
  endtask

  // Hand-computed expectation checked against both the DUT and the model.
  task automatic expect_lit(input string name, input int p, input logic [1:0] r,
                            input logic [31:0] d, input logic [1:0] t);
    n_cmp++;
    if (resp_w[p] !== r || rdata_w[p] !== d || rtag_w[p] !== t) begin
      n_fail++;
      $display("FAIL %s dut port%0d: got resp=%0d data=%h tag=%0d, want resp=%0d data=%h tag=%0d",
               name, p + 1, resp_w[p], rdata_w[p], rtag_w[p], r, d, t);
    end
    n_cmp++;
    if (exp_resp[p] !== r || exp_data[p] !== d || exp_tag[p] !== t) begin
      n_fail++;
      $display("FAIL %s model port%0d: got resp=%0d data=%h tag=%0d, want resp=%0d data=%h tag=%0d",
               name, p + 1, exp_resp[p], exp_data[p], exp_tag[p], r, d, t);
    end
    $display("txn %s port%0d resp=%0d data=%h tag=%0d", name, p + 1, resp_w[p], rdata_w[p], rtag_w[p]);
  endtask

  function automatic logic [3:0] rand_cmd();
    int r = $urandom_range(0, 9);
    logic [3:0] inv [10] = '{4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd15};
    case (r)
      0, 1, 2: return 4'd0;
      3, 4, 9: return 4'd1;
      5:       return 4'd2;
      6:       return 4'd5;
      7:       return 4'd6;
      default: return inv[$urandom_range(0, 9)];
    endcase
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 40));
      2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      default: return 32'h8000_0000 | 32'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int rst_left = 0;
    reset = 1'b1;
    idle_all();
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    expect_lit("reset_state", 0, 2'd0, 32'd0, 2'd0);

    // Port1 add 0x30 + 0x20.
    put(0, 4'd1, 32'h30, 2'd0); step();
    put(0, 4'd0, 32'h20, 2'd0); step();
    step(); step();
    expect_lit("add_basic", 0, 2'd1, 32'h50, 2'd0);
    repeat (3) step();

    // Port2 add overflow, port3 sub underflow (same unit, port2 first).
    put(1, 4'd1, 32'hFFFF_FFFF, 2'd3); put(2, 4'd2, 32'h5, 2'd1); step();
    put(1, 4'd0, 32'h1, 2'd0);         put(2, 4'd0, 32'h7, 2'd0); step();
    step(); step();
    expect_lit("add_overflow", 1, 2'd2, 32'd0, 2'd3);
    step();
    expect_lit("sub_underflow", 2, 2'd2, 32'd0, 2'd1);
    repeat (3) step();

    // Port3 sub equal operands gives a zero success.
    put(2, 4'd2, 32'h1234, 2'd2); step();
    put(2, 4'd0, 32'h1234, 2'd0); step();
    step(); step();
    expect_lit("sub_equal", 2, 2'd1, 32'd0, 2'd2);
    repeat (3) step();

    // Port4 back-to-back shifts: left by 0x24 (only low 5 bits), right by 31.
    put(3, 4'd5, 32'h1, 2'd2);          step();
    put(3, 4'd0, 32'h24, 2'd0);         step();
    put(3, 4'd6, 32'h8000_0000, 2'd1);  step();
    put(3, 4'd0, 32'd31, 2'd0);         step();
    expect_lit("shift_left", 3, 2'd1, 32'h10, 2'd2);
    step(); step();
    expect_lit("shift_right", 3, 2'd1, 32'h1, 2'd1);
    repeat (3) step();

    // All four ports add in the same cycle: serialized on ALU-A by port number.
    for (int p = 0; p < 4; p++) put(p, 4'd1, 32'(100 * (p + 1)), 2'(p));
    step();
    for (int p = 0; p < 4; p++) put(p, 4'd0, 32'(p + 1), 2'd0);
    step();
    step(); step();
    expect_lit("contend_p1", 0, 2'd1, 32'd101, 2'd0);
    step();
    expect_lit("contend_p2", 1, 2'd1, 32'd202, 2'd1);
    step();
    expect_lit("contend_p3", 2, 2'd1, 32'd303, 2'd2);
    step();
    expect_lit("contend_p4", 3, 2'd1, 32'd404, 2'd3);
    repeat (3) step();

    // Invalid command echoes its tag with an error.
    put(0, 4'd3, 32'hDEAD, 2'd2); step();
    put(0, 4'd0, 32'hBEEF, 2'd0); step();
    step(); step();
    expect_lit("invalid_cmd", 0, 2'd2, 32'd0, 2'd2);
    repeat (3) step();

    // Reset at the op2 edge discards the request.
    put(0, 4'd1, 32'd10, 2'd1); step();
    put(0, 4'd0, 32'd20, 2'd0); reset = 1'b1; step();
    reset = 1'b0;
    step(); step();
    expect_lit("reset_mid_req", 0, 2'd0, 32'd0, 2'd0);
    repeat (3) step();

    // Randomized load with occasional short resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (rst_left > 0) begin
        reset = 1'b1;
        rst_left--;
      end else if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        rst_left = $urandom_range(0, 2);
      end else begin
        reset = 1'b0;
      end
      for (int p = 0; p < 4; p++) put(p, rand_cmd(), rand_data(), 2'($urandom_range(0, 3)));
      step();
    end
    reset = 1'b0;
    idle_all();
    repeat (30) step();

    $display("info: model responses=%0d, full-queue drops=%0d", n_resp, n_drop);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
